// File: rtl/cam_16b8b.sv
// cam_16b8b: 16-bit pixel word to 8-bit byte serialiser.
// Words enter a small FIFO on a valid/ready handshake and leave as two
// consecutive bytes with a byte-enable, high byte first.
// Optional build macro CAM_16B8B_SWAP_EN: emit the low byte first instead.
`timescale 1ns/1ps

module cam_16b8b #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  IDLE_BYTE  = 8'h00
) (
  input  logic                          pixel_clk,
  input  logic                          rst_n,
  input  logic [15:0]                   data_i,
  input  logic                          data_de_i,
  output logic                          data_rdy_o,
  input  logic                          flush_i,
  output logic [7:0]                    data_o,
  output logic                          data_de_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  // State names the byte currently presented on data_o.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [15:0]    mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]  level_reg;
  logic [7:0]     hold_reg;
  logic [7:0]     data_next;
  logic           de_next;
  logic           push, pop;
  logic [15:0]    head;
  logic [7:0]     head_first, head_second;

  assign head       = mem[rd_ptr_reg];
  assign level_o    = level_reg;
  assign data_rdy_o = (level_reg != LW'(FIFO_DEPTH));
  // A flush discards any word offered at the same edge.
  assign push       = data_de_i && data_rdy_o && !flush_i;

`ifdef CAM_16B8B_SWAP_EN
  assign head_first  = head[7:0];
  assign head_second = head[15:8];
`else
  assign head_first  = head[15:8];
  assign head_second = head[7:0];
`endif

  // FIFO storage: plain write port, no reset needed on the contents.
  always_ff @(posedge pixel_clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= data_i;
    end
  end

  // FIFO pointers and occupancy; flush empties everything at once.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Next-state and next-output decode; pops only when a word boundary is reached.
  always_comb begin
    state_next = state_reg;
    data_next  = IDLE_BYTE;
    de_next    = 1'b0;
    pop        = 1'b0;
    if (flush_i) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_HI: begin
          data_next  = hold_reg;
          de_next    = 1'b1;
          state_next = S_LO;
        end
        default: begin
          if (level_reg != '0) begin
            pop        = 1'b1;
            data_next  = head_first;
            de_next    = 1'b1;
            state_next = S_HI;
          end else begin
            state_next = S_IDLE;
          end
        end
      endcase
    end
  end

  // State, output byte and the pending second byte of the current word.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      data_o    <= IDLE_BYTE;
      data_de_o <= 1'b0;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      data_o    <= data_next;
      data_de_o <= de_next;
      if (pop) hold_reg <= head_second;
    end
  end

endmodule

// File: tb/tb_cam_16b8b.sv
// tb_cam_16b8b: directed checks for cam_16b8b (reset, single word, burst with
// back-pressure, flush mid-word, asynchronous reset mid-burst).
`timescale 1ns/1ps

module tb_cam_16b8b;

  localparam int DEPTH = 4;

  logic        pixel_clk = 1'b0;
  logic        rst_n     = 1'b0;
  logic [15:0] data_i    = '0;
  logic        data_de_i = 1'b0;
  logic        flush_i   = 1'b0;
  logic        data_rdy_o;
  logic [7:0]  data_o;
  logic        data_de_o;
  logic [2:0]  level_o;

  int checks = 0;
  int errors = 0;

  cam_16b8b #(.FIFO_DEPTH(DEPTH), .IDLE_BYTE(8'h00)) dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .data_i    (data_i),
    .data_de_i (data_de_i),
    .data_rdy_o(data_rdy_o),
    .flush_i   (flush_i),
    .data_o    (data_o),
    .data_de_o (data_de_o),
    .level_o   (level_o)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Expected byte order of a word on the output.
  function automatic logic [7:0] fb(input logic [15:0] w);
`ifdef CAM_16B8B_SWAP_EN
    return w[7:0];
`else
    return w[15:8];
`endif
  endfunction

  function automatic logic [7:0] sb(input logic [15:0] w);
`ifdef CAM_16B8B_SWAP_EN
    return w[15:8];
`else
    return w[7:0];
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level_o); end
    checks++; if (data_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b want 1", data_rdy_o); end
    checks++; if (data_de_o !== 1'b0) begin errors++; $display("FAIL reset_de got %b want 0", data_de_o); end
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_o); end
    @(negedge pixel_clk);
    rst_n = 1'b1;
    $display("reset released at %0t", $time);
  endtask

  task automatic test_single_write();
    @(negedge pixel_clk);
    data_i = 16'hA55A; data_de_i = 1'b1;
    @(posedge pixel_clk);                  // edge N
    @(negedge pixel_clk);
    data_de_i = 1'b0;
    checks++; if (level_o !== 3'd1) begin errors++; $display("FAIL single_level_n got %0d want 1", level_o); end
    checks++; if (data_de_o !== 1'b0) begin errors++; $display("FAIL single_de_n got %b want 0", data_de_o); end
    @(negedge pixel_clk);                  // after N+1
    checks++; if (data_o !== fb(16'hA55A) || data_de_o !== 1'b1) begin errors++; $display("FAIL single_byte1 got %h/%b want %h/1", data_o, data_de_o, fb(16'hA55A)); end
    checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL single_level_n1 got %0d want 0", level_o); end
    @(negedge pixel_clk);                  // after N+2
    checks++; if (data_o !== sb(16'hA55A) || data_de_o !== 1'b1) begin errors++; $display("FAIL single_byte2 got %h/%b want %h/1", data_o, data_de_o, sb(16'hA55A)); end
    @(negedge pixel_clk);                  // after N+3
    checks++; if (data_o !== 8'h00 || data_de_o !== 1'b0) begin errors++; $display("FAIL single_idle got %h/%b want 00/0", data_o, data_de_o); end
    $display("single word A55A emitted");
  endtask

  // Eight words pushed at full rate; DEAD is offered whenever the FIFO is full.
  task automatic test_burst_full();
    logic [15:0] words [8];
    logic [7:0]  exp_bytes [16];
    int full_seen = 0;
    int nbytes = 0;
    int gaps = 0;
    int max_level = 0;
    for (int i = 0; i < 8; i++) begin
      words[i] = {8'(2*i+1), 8'(2*i+2)};
      exp_bytes[2*i]   = fb(words[i]);
      exp_bytes[2*i+1] = sb(words[i]);
    end
    fork
      begin : driver
        int idx = 0;
        int cyc = 0;
        logic acc;
        while (idx < 8 && cyc < 100) begin
          @(negedge pixel_clk);
          cyc++;
          acc = data_rdy_o;
          data_de_i = 1'b1;
          if (acc) begin
            data_i = words[idx];
          end else begin
            data_i = 16'hDEAD;
            full_seen++;
            checks++; if (level_o !== 3'd4) begin errors++; $display("FAIL burst_notready_level got %0d want 4", level_o); end
          end
          @(posedge pixel_clk);
          if (acc) begin
            $display("pushed word %h", words[idx]);
            idx++;
          end
        end
        @(negedge pixel_clk);
        data_de_i = 1'b0;
        checks++; if (idx !== 8) begin errors++; $display("FAIL burst_pushed got %0d want 8", idx); end
      end
      begin : monitor
        int cyc = 0;
        while (nbytes < 16 && cyc < 200) begin
          @(negedge pixel_clk);
          cyc++;
          if (int'(level_o) > max_level) max_level = int'(level_o);
          if (data_de_o) begin
            $display("byte %0d = %h", nbytes, data_o);
            checks++; if (data_o !== exp_bytes[nbytes]) begin errors++; $display("FAIL burst_byte%0d got %h want %h", nbytes, data_o, exp_bytes[nbytes]); end
            nbytes++;
          end else if (nbytes > 0) begin
            gaps++;
          end
        end
      end
    join
    checks++; if (nbytes !== 16) begin errors++; $display("FAIL burst_count got %0d want 16", nbytes); end
    checks++; if (gaps !== 0) begin errors++; $display("FAIL burst_gaps got %0d want 0", gaps); end
    checks++; if (max_level !== 4) begin errors++; $display("FAIL burst_max_level got %0d want 4", max_level); end
    checks++; if (full_seen == 0) begin errors++; $display("FAIL burst_full_seen got 0 want >0"); end
    @(negedge pixel_clk);
    checks++; if (data_de_o !== 1'b0 || level_o !== 3'd0) begin errors++; $display("FAIL burst_drained got %b/%0d want 0/0", data_de_o, level_o); end
  endtask

  task automatic test_flush();
    logic [15:0] wl [4];
    wl[0] = 16'h0A0B; wl[1] = 16'h1234; wl[2] = 16'h1111; wl[3] = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      @(negedge pixel_clk);
      data_i = wl[i]; data_de_i = 1'b1;
      @(posedge pixel_clk);
    end
    @(negedge pixel_clk);
    data_de_i = 1'b0;
    checks++; if (data_o !== fb(16'h1234) || data_de_o !== 1'b1) begin errors++; $display("FAIL flush_pre_byte got %h/%b want %h/1", data_o, data_de_o, fb(16'h1234)); end
    checks++; if (level_o !== 3'd2) begin errors++; $display("FAIL flush_pre_level got %0d want 2", level_o); end
    flush_i = 1'b1;
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    flush_i = 1'b0;
    checks++; if (data_de_o !== 1'b0 || data_o !== 8'h00) begin errors++; $display("FAIL flush_out got %h/%b want 00/0", data_o, data_de_o); end
    checks++; if (level_o !== 3'd0 || data_rdy_o !== 1'b1) begin errors++; $display("FAIL flush_level got %0d/%b want 0/1", level_o, data_rdy_o); end
    for (int i = 0; i < 3; i++) begin
      @(negedge pixel_clk);
      checks++; if (data_de_o !== 1'b0) begin errors++; $display("FAIL flush_quiet%0d got de=%b data=%h want de=0", i, data_de_o, data_o); end
    end
    $display("flush done, writing BEEF");
    @(negedge pixel_clk);
    data_i = 16'hBEEF; data_de_i = 1'b1;
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    data_de_i = 1'b0;
    @(negedge pixel_clk);
    checks++; if (data_o !== fb(16'hBEEF) || data_de_o !== 1'b1) begin errors++; $display("FAIL flush_beef1 got %h/%b want %h/1", data_o, data_de_o, fb(16'hBEEF)); end
    @(negedge pixel_clk);
    checks++; if (data_o !== sb(16'hBEEF) || data_de_o !== 1'b1) begin errors++; $display("FAIL flush_beef2 got %h/%b want %h/1", data_o, data_de_o, sb(16'hBEEF)); end
    @(negedge pixel_clk);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge pixel_clk);
      data_i = 16'h5000 + 16'(i); data_de_i = 1'b1;
      @(posedge pixel_clk);
    end
    #2;
    checks++; if (data_de_o !== 1'b1 || level_o === 3'd0) begin errors++; $display("FAIL arst_pre got de=%b level=%0d want de=1 level>0", data_de_o, level_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (data_de_o !== 1'b0 || data_o !== 8'h00) begin errors++; $display("FAIL arst_out got %h/%b want 00/0", data_o, data_de_o); end
    checks++; if (level_o !== 3'd0 || data_rdy_o !== 1'b1) begin errors++; $display("FAIL arst_level got %0d/%b want 0/1", level_o, data_rdy_o); end
    data_de_i = 1'b0;
    @(negedge pixel_clk);
    rst_n = 1'b1;
    @(negedge pixel_clk);
    data_i = 16'hC3D4; data_de_i = 1'b1;
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    data_de_i = 1'b0;
    @(negedge pixel_clk);
    checks++; if (data_o !== fb(16'hC3D4) || data_de_o !== 1'b1) begin errors++; $display("FAIL arst_resume1 got %h/%b want %h/1", data_o, data_de_o, fb(16'hC3D4)); end
    @(negedge pixel_clk);
    checks++; if (data_o !== sb(16'hC3D4) || data_de_o !== 1'b1) begin errors++; $display("FAIL arst_resume2 got %h/%b want %h/1", data_o, data_de_o, sb(16'hC3D4)); end
    @(negedge pixel_clk);
    checks++; if (data_de_o !== 1'b0) begin errors++; $display("FAIL arst_resume_idle got %b want 0", data_de_o); end
    $display("async reset recovery done");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_full();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_16b8b.md
Name: cam_16b8b

Overview:
- Transmit-side counterpart of the 8-to-16-bit camera receive path.
- Accepts 16-bit pixel words on a valid/ready handshake and buffers them in a small FIFO.
- Serialises each word into two consecutive 8-bit bytes with a byte-enable, high byte first by default.
- Sits between the 16-bit pixel pipeline and an 8-bit camera/display-style parallel output, all on one pixel clock.

Parameters:
- FIFO_DEPTH, 4: input word FIFO depth; power of two, at least 2.
- IDLE_BYTE, 8'h00: value driven on data_o while data_de_o=0.

Ports:
- pixel_clk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_i  in  16  input pixel word.
- data_de_i  in  1  input word valid.
- data_rdy_o  out  1  FIFO can accept a word (= not full).
- flush_i  in  1  synchronous flush of FIFO and serialiser.
- data_o  out  8  output byte (registered).
- data_de_o  out  1  output byte valid (registered).
- level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (rst_n=0, asynchronous):
  - FIFO empty, level_o=0, data_rdy_o=1.
  - data_o=IDLE_BYTE, data_de_o=0, state=S_IDLE.
- Write: a word is accepted at a rising edge when data_de_i=1 and data_rdy_o=1. data_de_i while data_rdy_o=0 is ignored; the word is not stored and the source must hold it.
- data_rdy_o = (level_o != FIFO_DEPTH). It is derived from registered state only.
- FSM, where the state names the byte currently on data_o:
  - S_IDLE or S_LO, FIFO non-empty: pop head into hold register; data_o<=head[15:8], data_de_o<=1, ->S_HI.
  - S_IDLE or S_LO, FIFO empty: data_o<=IDLE_BYTE, data_de_o<=0, ->S_IDLE.
  - S_HI: data_o<=hold[7:0], data_de_o<=1, ->S_LO. S_HI never pops.
- Latency:
  - A word written at edge N into an empty FIFO is popped at edge N+1.
  - High byte is valid after edge N+1; low byte is valid after edge N+2.
- Throughput:
  - One word per 2 cycles, with no gap between words while the FIFO stays non-empty.
  - Sustained input at 1 word/cycle fills the FIFO and throttles via data_rdy_o.
- Simultaneous push and pop at one edge: level_o unchanged, both take effect; legal at any level < FIFO_DEPTH.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. level_o never exceeds FIFO_DEPTH and never underflows.
- Every output byte is half of a word in order; a high byte is never emitted without its low byte, except on flush or reset.
- flush_i=1 at an edge:
  - FIFO emptied, level_o<=0.
  - Any push at that same edge is discarded.
  - data_o<=IDLE_BYTE, data_de_o<=0, ->S_IDLE, even mid-word (pending low byte dropped).
  - Flush wins over push and pop.
- Reset mid-word: same effect as flush, applied asynchronously.

Optional Feature:
- Macro: CAM_16B8B_SWAP_EN.
- Defined: byte order swapped. First byte = word[7:0], second byte = word[15:8]. All timing unchanged.
- Undefined: high byte first, as specified above.

Test Plan:
- Reset, then single write of 16'hA55A at edge N:
  - data_o=8'hA5/de=1 after N+1, 8'h5A/de=1 after N+2.
  - de=0 and data_o=8'h00 after N+3.
  - level_o 1 after N, 0 after N+1.
- Burst of 8 words 16'h0102..16'h0F10 (FIFO_DEPTH=4), data_de_i held high and advancing only on data_rdy_o:
  - data_rdy_o drops once level_o=4.
  - 16 output bytes 01,02,03,04,... contiguous with de=1 and no gaps; no word lost.
- Push while full: data_de_i=1, data_rdy_o=0 with 16'hDEAD:
  - 16'hDEAD never appears; level_o stays 4.
  - Output sequence unchanged.
- flush_i pulsed while in S_HI of word 16'h1234 with 2 words queued:
  - Next cycle data_de_o=0, level_o=0, 8'h34 never emitted.
  - A subsequent write of 16'hBEEF emits BE then EF.
- rst_n asserted asynchronously mid-burst:
  - data_de_o=0, data_o=8'h00, level_o=0, data_rdy_o=1 immediately.
  - Normal operation resumes after release.
- With CAM_16B8B_SWAP_EN defined, word 16'hA55A: output bytes 8'h5A then 8'hA5 with identical timing.
